// File: rtl/mux_rr_n.sv
// mux_rr_n: N-channel to one registered output mux with manual or round-robin
// channel selection, a single-word output buffer and an accepted-word counter.
module mux_rr_n #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SELW     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel_in,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SELW-1:0]           out_sel,
    output logic [7:0]                xfer_cnt
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [SELW-1:0] LAST_CH = SELW'(CHANNELS - 1);

    logic [0:0]      state;
    logic [0:0]      state_next;
    logic [SELW-1:0] ptr;

    logic            can_accept;
    logic            accept;

    logic            man_vld;
    logic [SELW-1:0] man_grant;
    logic            rr_vld;
    logic [SELW-1:0] rr_grant;
    logic            grant_vld;
    logic [SELW-1:0] grant;
    logic [WIDTH-1:0] grant_word;

    // Manual grant: sel_in must name an existing channel that has a word.
    always_comb begin
        man_vld   = 1'b0;
        man_grant = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (sel_in == SELW'(i) && in_valid[i]) begin
                man_vld   = 1'b1;
                man_grant = SELW'(i);
            end
        end
    end

    // Round-robin grant: first valid channel searching ptr, ptr+1, ... with wrap.
    always_comb begin
        int unsigned cand;
        rr_vld   = 1'b0;
        rr_grant = '0;
        cand     = 0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            cand = (32'(ptr) + k) % CHANNELS;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (!rr_vld && cand == i && in_valid[i]) begin
                    rr_vld   = 1'b1;
                    rr_grant = SELW'(i);
                end
            end
        end
    end

    // Grant selection, acceptance and per-channel ready strobes.
    always_comb begin
        grant_vld  = mode ? rr_vld   : man_vld;
        grant      = mode ? rr_grant : man_grant;
        can_accept = !rst && ((state == ST_EMPTY) || out_ready);
        accept     = can_accept && grant_vld;
        in_ready   = '0;
        grant_word = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant == SELW'(i)) begin
                grant_word  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = accept;
            end
        end
    end

    // Output buffer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fill on accept, drain on consume without refill.
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready && !accept) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    assign out_valid = (state == ST_FULL);

    // Output word, source index, scan pointer and accept counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
            xfer_cnt <= '0;
        end else if (accept) begin
            out_data <= grant_word;
            out_sel  <= grant;
            xfer_cnt <= xfer_cnt + 8'd1;
            if (mode) begin
                ptr <= (grant == LAST_CH) ? '0 : grant + SELW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed bench for mux_rr_n: vector table for the 4-channel instance plus
// hand sequences for counter wrap and out-of-range select on a 3-channel instance.
module tb_mux_rr_n;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [1:0]  sel_in;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_sel;
    logic [7:0]  xfer_cnt;

    logic        rst3;
    logic        mode3;
    logic [1:0]  sel_in3;
    logic [11:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [3:0]  out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  out_sel3;
    logic [7:0]  xfer_cnt3;

    int checks = 0;
    int errors = 0;

    mux_rr_n #(.WIDTH(4), .CHANNELS(4), .SELW(2)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .sel_in(sel_in),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sel(out_sel), .xfer_cnt(xfer_cnt)
    );

    mux_rr_n #(.WIDTH(4), .CHANNELS(3), .SELW(2)) u_dut3 (
        .clk(clk), .rst(rst3), .mode(mode3), .sel_in(sel_in3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_sel(out_sel3), .xfer_cnt(xfer_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        mode;
        logic [1:0]  sel;
        logic [15:0] data;
        logic [3:0]  valid;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [3:0]  exp_od;
        logic [1:0]  exp_os;
        logic [7:0]  exp_cnt;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic r, logic m, logic [1:0] s, logic [15:0] d,
                                logic [3:0] v, logic o, logic [3:0] er, logic eov,
                                logic [3:0] eod, logic [1:0] eos, logic [7:0] ec);
        vec_t t;
        t.rst = r; t.mode = m; t.sel = s; t.data = d; t.valid = v; t.ordy = o;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_os = eos; t.exp_cnt = ec;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel_in = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
        rst3 = 1'b1; mode3 = 1'b0; sel_in3 = '0; in_data3 = '0; in_valid3 = '0; out_ready3 = 1'b0;

        //          rst  mode sel   data      valid    ordy  rdy      ov    od     os    cnt
        vecs[0]  = mk(1, 1, 2'd0, 16'h4321, 4'b1111, 1, 4'b0000, 0, 4'h0, 2'd0, 8'd0);
        vecs[1]  = mk(0, 0, 2'd2, 16'h0A00, 4'b0100, 1, 4'b0100, 1, 4'hA, 2'd2, 8'd1);
        vecs[2]  = mk(0, 0, 2'd2, 16'h0A00, 4'b0000, 1, 4'b0000, 0, 4'hA, 2'd2, 8'd1);
        vecs[3]  = mk(0, 0, 2'd1, 16'h4321, 4'b0010, 0, 4'b0010, 1, 4'h2, 2'd1, 8'd2);
        vecs[4]  = mk(0, 0, 2'd3, 16'h4321, 4'b1111, 0, 4'b0000, 1, 4'h2, 2'd1, 8'd2);
        vecs[5]  = mk(0, 0, 2'd3, 16'h4321, 4'b1111, 0, 4'b0000, 1, 4'h2, 2'd1, 8'd2);
        vecs[6]  = mk(0, 0, 2'd3, 16'h4321, 4'b1111, 0, 4'b0000, 1, 4'h2, 2'd1, 8'd2);
        vecs[7]  = mk(0, 0, 2'd3, 16'h4321, 4'b1111, 1, 4'b1000, 1, 4'h4, 2'd3, 8'd3);
        vecs[8]  = mk(0, 0, 2'd0, 16'h4321, 4'b1111, 1, 4'b0001, 1, 4'h1, 2'd0, 8'd4);
        vecs[9]  = mk(0, 1, 2'd0, 16'h4321, 4'b1111, 1, 4'b0001, 1, 4'h1, 2'd0, 8'd5);
        vecs[10] = mk(0, 1, 2'd0, 16'h4321, 4'b1111, 1, 4'b0010, 1, 4'h2, 2'd1, 8'd6);
        vecs[11] = mk(0, 1, 2'd0, 16'h4321, 4'b1111, 1, 4'b0100, 1, 4'h3, 2'd2, 8'd7);
        vecs[12] = mk(0, 1, 2'd0, 16'h4321, 4'b1111, 1, 4'b1000, 1, 4'h4, 2'd3, 8'd8);
        vecs[13] = mk(0, 1, 2'd0, 16'h4321, 4'b1111, 1, 4'b0001, 1, 4'h1, 2'd0, 8'd9);
        vecs[14] = mk(0, 1, 2'd0, 16'h4321, 4'b1001, 1, 4'b1000, 1, 4'h4, 2'd3, 8'd10);
        vecs[15] = mk(0, 1, 2'd0, 16'h4321, 4'b1001, 1, 4'b0001, 1, 4'h1, 2'd0, 8'd11);
        vecs[16] = mk(0, 0, 2'd2, 16'h4321, 4'b1111, 1, 4'b0100, 1, 4'h3, 2'd2, 8'd12);
        vecs[17] = mk(0, 1, 2'd0, 16'h4321, 4'b1111, 1, 4'b0010, 1, 4'h2, 2'd1, 8'd13);
        vecs[18] = mk(1, 1, 2'd0, 16'h4321, 4'b1111, 0, 4'b0000, 0, 4'h0, 2'd0, 8'd0);
        vecs[19] = mk(0, 1, 2'd0, 16'h4321, 4'b1111, 0, 4'b0001, 1, 4'h1, 2'd0, 8'd1);

        @(negedge clk);
        for (int n = 0; n < NVEC; n++) begin
            rst = vecs[n].rst; mode = vecs[n].mode; sel_in = vecs[n].sel;
            in_data = vecs[n].data; in_valid = vecs[n].valid; out_ready = vecs[n].ordy;
            #1;
            check($sformatf("v%0d in_ready", n), 32'(in_ready), 32'(vecs[n].exp_rdy));
            @(posedge clk); #1;
            check($sformatf("v%0d out_valid", n), 32'(out_valid), 32'(vecs[n].exp_ov));
            check($sformatf("v%0d out_data", n), 32'(out_data), 32'(vecs[n].exp_od));
            check($sformatf("v%0d out_sel", n), 32'(out_sel), 32'(vecs[n].exp_os));
            check($sformatf("v%0d xfer_cnt", n), 32'(xfer_cnt), 32'(vecs[n].exp_cnt));
            @(negedge clk);
        end

        // Counter wrap: 254 more accepts reach 255, the next one wraps to 0.
        mode = 1'b0; sel_in = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
        for (int n = 0; n < 254; n++) @(negedge clk);
        check("cnt_255", 32'(xfer_cnt), 32'd255);
        @(negedge clk);
        check("cnt_wrap", 32'(xfer_cnt), 32'd0);
        check("cnt_wrap out_valid", 32'(out_valid), 32'd1);

        // Three-channel instance: sel_in=3 names no channel.
        @(negedge clk);
        rst3 = 1'b0; mode3 = 1'b0; sel_in3 = 2'd3; in_data3 = 12'h765; in_valid3 = 3'b111; out_ready3 = 1'b1;
        #1;
        check("c3 sel3 in_ready", 32'(in_ready3), 32'd0);
        @(negedge clk);
        check("c3 sel3 out_valid", 32'(out_valid3), 32'd0);
        check("c3 sel3 xfer_cnt", 32'(xfer_cnt3), 32'd0);
        sel_in3 = 2'd2; #1;
        check("c3 sel2 in_ready", 32'(in_ready3), 32'b100);
        @(negedge clk);
        check("c3 sel2 out_data", 32'(out_data3), 32'h7);
        check("c3 sel2 out_sel", 32'(out_sel3), 32'd2);
        sel_in3 = 2'd3; out_ready3 = 1'b0; #1;
        check("c3 held in_ready", 32'(in_ready3), 32'd0);
        @(negedge clk);
        check("c3 held out_valid", 32'(out_valid3), 32'd1);
        check("c3 held out_data", 32'(out_data3), 32'h7);
        check("c3 held xfer_cnt", 32'(xfer_cnt3), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_n.md
MUX_RR_N -- requirements
Module: mux_rr_n

Interface
REQ-001 Parameter WIDTH, default 4, data bits per channel (1..32).
REQ-002 Parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 Parameter SELW, default 2, select/index width; SHALL satisfy 2**SELW >= CHANNELS.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 mode  input  1  0 = manual select, 1 = round-robin scan.
REQ-007 sel_in  input  SELW  channel index used in manual mode.
REQ-008 in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  CHANNELS  per-channel word available.
REQ-010 in_ready  output  CHANNELS  per-channel accept strobe; combinational.
REQ-011 out_data  output  WIDTH  registered selected word.
REQ-012 out_valid  output  1  out_data holds an unconsumed word.
REQ-013 out_ready  input  1  downstream consumes word when out_valid & out_ready.
REQ-014 out_sel  output  SELW  index of the channel that supplied out_data.
REQ-015 xfer_cnt  output  8  count of accepted input words, wraps 255 -> 0.

Function
REQ-016 Block SHALL hold one output word (states EMPTY: out_valid=0, FULL: out_valid=1).
REQ-017 can_accept SHALL be 1 in EMPTY, or in FULL when out_ready=1 in the same cycle.
REQ-018 Manual mode: grant SHALL be sel_in when sel_in < CHANNELS and in_valid[sel_in]=1; otherwise no grant.
REQ-019 Round-robin mode: grant SHALL be the first channel with in_valid=1 searching ptr, ptr+1, ... CHANNELS-1, 0, ... ptr-1; no grant if all in_valid=0.
REQ-020 in_ready[i] SHALL be 1 only when can_accept=1 and grant=i; at most one bit set per cycle.
REQ-021 Accept (grant present and can_accept): next cycle out_data = granted word, out_sel = grant, out_valid = 1; latency 1 cycle.
REQ-022 Consume without accept: next cycle out_valid = 0; out_data, out_sel retain values.
REQ-023 Simultaneous consume and accept SHALL replace the word with no bubble (full throughput, one word per cycle).
REQ-024 FULL with out_ready=0: out_data, out_sel, out_valid SHALL hold; all in_ready = 0.
REQ-025 ptr (SELW bits, internal) SHALL update only on round-robin accept, to grant+1, wrapping CHANNELS-1 -> 0.
REQ-026 Manual-mode accepts SHALL NOT change ptr; mode changes SHALL NOT reset ptr and take effect in the same cycle's grant.
REQ-027 xfer_cnt SHALL increment by 1 on every accept in either mode, modulo 256.
REQ-028 sel_in >= CHANNELS in manual mode SHALL produce no grant and no error; held word unaffected.

Reset
REQ-029 rst=1 at a rising edge SHALL set out_valid=0, out_data=0, out_sel=0, ptr=0, xfer_cnt=0, regardless of other inputs.
REQ-030 While rst=1, in_ready SHALL be all 0; a word held at reset SHALL be discarded.
REQ-031 First accept SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-032 Manual: CHANNELS=4, WIDTH=4, mode=0, sel_in=2, in_valid=4'b0100, ch2=4'hA, out_ready=1 -> in_ready=4'b0100; next cycle out_data=4'hA, out_sel=2, out_valid=1, xfer_cnt=1.
REQ-033 Round-robin fairness: mode=1, in_valid=4'b1111 constant, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, no gaps.
REQ-034 Skip: mode=1, ptr=1, in_valid=4'b1001 -> grant 3, then ptr=0 and next grant 0.
REQ-035 Backpressure: FULL with out_ready=0 for 3 cycles -> out_data stable, in_ready=0; out_ready=1 with in_valid set -> back-to-back replacement.
REQ-036 Boundaries: sel_in=3 on CHANNELS=3 -> no grant; 256 accepts -> xfer_cnt=0; rst asserted while FULL -> out_valid=0, ptr=0 next cycle.
